// File: rtl/stream_pool2d.sv
// Purpose: streaming multi-channel POOLxPOOL max/average pooling over a raster pixel stream.
// Latency: 1 cycle from the accept that completes a window to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; counters and accumulators freeze while stalled.
// Ports: clock/reset (async, active-high); mode (0=max, 1=avg, taken on a frame's first beat);
//        in_valid/in_ready/in_data/in_last input stream; out_valid/out_ready/out_data/out_last
//        pooled stream; frame_err sticky flag for an in_last position mismatch.
module stream_pool2d #(
    parameter int IMG_W     = 254,
    parameter int IMG_H     = 254,
    parameter int POOL      = 2,
    parameter int CHANNELS  = 4,
    parameter int WIDTH_BIT = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*WIDTH_BIT-1:0] in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*WIDTH_BIT-1:0] out_data,
    output logic                          out_last,
    output logic                          frame_err
);
    localparam int LOG2P = $clog2(POOL);
    localparam int SH    = 2 * LOG2P;            // log2 of samples per window
    localparam int AW    = WIDTH_BIT + SH;       // accumulator lane width: full window sum fits
    localparam int NWIN  = IMG_W / POOL;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int WCW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    if (IMG_W % POOL != 0) begin : g_chk_w
        $error("IMG_W must be a multiple of POOL");
    end
    if (IMG_H % POOL != 0) begin : g_chk_h
        $error("IMG_H must be a multiple of POOL");
    end
    if ((POOL < 2) || ((POOL & (POOL - 1)) != 0)) begin : g_chk_p
        $error("POOL must be a power of 2 and at least 2");
    end

    logic [CW-1:0]                   col_q, col_d;
    logic [RW-1:0]                   row_q, row_d;
    logic                            mode_q, mode_d;
    logic                            out_valid_q, out_valid_d;
    logic [CHANNELS*WIDTH_BIT-1:0]   out_data_q, out_data_d;
    logic                            out_last_q, out_last_d;
    logic                            frame_err_q, frame_err_d;
    logic signed [AW-1:0]            acc_q [NWIN][CHANNELS];

    logic                            accept, first_px, at_end, loc_first, loc_last;
    logic                            avg_mode, complete;
    logic [WCW-1:0]                  wc;
    logic signed [AW-1:0]            nv [CHANNELS];
    logic [CHANNELS*WIDTH_BIT-1:0]   res_dat;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign first_px  = (col_q == '0) && (row_q == '0);
    assign at_end    = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign loc_first = (col_q[LOG2P-1:0] == '0) && (row_q[LOG2P-1:0] == '0);
    // POOL is a power of 2, so POOL-1 is the all-ones local offset.
    assign loc_last  = (col_q[LOG2P-1:0] == {LOG2P{1'b1}}) && (row_q[LOG2P-1:0] == {LOG2P{1'b1}});
    // The frame's first beat must already use the mode it is latching.
    assign avg_mode  = first_px ? mode : mode_q;
    assign complete  = accept && loc_last;
    assign wc        = WCW'(col_q >> LOG2P);

    // Per-lane window update and the pooled result if this beat closes the window.
    always_comb begin
        logic signed [AW-1:0] ext;
        logic signed [AW-1:0] cur;
        ext     = '0;
        cur     = '0;
        res_dat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ext = {{SH{in_data[c*WIDTH_BIT+WIDTH_BIT-1]}}, in_data[c*WIDTH_BIT +: WIDTH_BIT]};
            cur = acc_q[wc][c];
            if (loc_first) begin
                nv[c] = ext;
            end else if (avg_mode) begin
                nv[c] = cur + ext;
            end else begin
                nv[c] = (ext > cur) ? ext : cur;
            end
            // AW = WIDTH_BIT + SH, so the top WIDTH_BIT bits are the floored, truncated average.
            res_dat[c*WIDTH_BIT +: WIDTH_BIT] = avg_mode ? nv[c][SH +: WIDTH_BIT]
                                                         : nv[c][WIDTH_BIT-1:0];
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        frame_err_d = frame_err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (accept) begin
            if (first_px) begin
                mode_d = mode;
            end
            if (in_last && !at_end) begin
                // Early frame end: resync so the next beat starts a new frame.
                frame_err_d = 1'b1;
                col_d       = '0;
                row_d       = '0;
            end else begin
                if (at_end && !in_last) begin
                    frame_err_d = 1'b1;
                end
                if (col_q == CW'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end

        if (complete) begin
            out_valid_d = 1'b1;
            out_data_d  = res_dat;
            out_last_d  = at_end;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int w = 0; w < NWIN; w++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc_q[w][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
            if (accept) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc_q[wc][c] <= nv[c];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_stream_pool2d.sv
// Purpose: directed self-checking bench for stream_pool2d on a 4x4, POOL 2, 2-lane frame.
// Latency: checks the 1-cycle completion-to-out_valid timing on the first frame.
// Backpressure: stalls out_ready for 5 cycles and checks in_ready drops and the output holds.
module tb_stream_pool2d;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int P  = 2;
    localparam int CH = 2;
    localparam int WB = 16;

    logic              clock     = 1'b0;
    logic              reset     = 1'b1;
    logic              mode      = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_last   = 1'b0;
    logic              out_ready = 1'b1;
    logic [CH*WB-1:0]  in_data   = '0;
    logic              in_ready;
    logic              out_valid;
    logic [CH*WB-1:0]  out_data;
    logic              out_last;
    logic              frame_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_dat [$];
    logic        q_last [$];

    stream_pool2d #(
        .IMG_W(W), .IMG_H(H), .POOL(P), .CHANNELS(CH), .WIDTH_BIT(WB)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    // Record every output handshake (it completes on the following rising edge).
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            q_dat.push_back(out_data);
            q_last.push_back(out_last);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1);
        logic [15:0] a;
        logic [15:0] b;
        a = l0[15:0];
        b = l1[15:0];
        return {b, a};
    endfunction

    // kind 0: lane0 = 1..16, lane1 = -1..-16.  kind 1: lane0 window {-1,-2,-3,-4}, lane1 -32768.
    function automatic logic [31:0] pix(input int kind, input int i);
        int r;
        int c;
        r = i / W;
        c = i % W;
        if (kind == 0) return pk(i + 1, -(i + 1));
        return pk(-(1 + 2 * (r % 2) + (c % 2)), -32768);
    endfunction

    task automatic send_pixel(input logic [31:0] d, input logic last, input logic md);
        int g;
        g        = 0;
        in_data  = d;
        in_last  = last;
        mode     = md;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && g < 200) begin
            g++;
            @(negedge clock);
        end
        if (g >= 200) check("accept_timeout", 1, 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int kind, input logic md_first, input logic md_rest,
                              input int npix, input int last_at, input bit lat);
        for (int i = 0; i < npix; i++) begin
            send_pixel(pix(kind, i), (i == last_at), (i == 0) ? md_first : md_rest);
            if (lat) check($sformatf("lat_valid_%0d", i), out_valid,
                           (i == 5 || i == 7 || i == 13 || i == 15));
        end
    endtask

    task automatic expect_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_count"}, q_dat.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < q_dat.size()) begin
                check($sformatf("%s_dat%0d", tag, k), q_dat[k], e[k]);
                check($sformatf("%s_last%0d", tag, k), q_last[k], (k == 3));
            end
        end
        q_dat.delete();
        q_last.delete();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Max mode with latency check
        send_frame(0, 1'b0, 1'b0, 16, 15, 1'b1);
        expect_frame("max", pk(6, -1), pk(8, -3), pk(14, -9), pk(16, -11));

        // Average mode, floor on negative lane
        send_frame(0, 1'b1, 1'b1, 16, 15, 1'b0);
        expect_frame("avg", pk(3, -4), pk(5, -6), pk(11, -12), pk(13, -14));

        // Signed average, extreme negative lane
        send_frame(1, 1'b1, 1'b1, 16, 15, 1'b0);
        expect_frame("savg", pk(-3, -32768), pk(-3, -32768), pk(-3, -32768), pk(-3, -32768));
        check("clean_frame_err", frame_err, 0);

        // Back-pressure: hold out_ready low for 5 cycles after the first result
        fork
            send_frame(0, 1'b0, 1'b0, 16, 15, 1'b0);
            begin
                int g;
                g = 0;
                do begin
                    @(posedge clock);
                    #1;
                    g++;
                end while (!out_valid && g < 100);
                check("bp_first_valid", out_valid, 1);
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock);
                    check($sformatf("bp_in_ready%0d", k), in_ready, 0);
                    check($sformatf("bp_hold%0d", k), out_data, pk(6, -1));
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        expect_frame("bp", pk(6, -1), pk(8, -3), pk(14, -9), pk(16, -11));

        // Early in_last at pixel index 10
        send_frame(0, 1'b0, 1'b0, 11, 10, 1'b0);
        check("err_set", frame_err, 1);
        repeat (3) @(posedge clock);
        #1;
        check("err_count", q_dat.size(), 2);
        if (q_dat.size() > 0) check("err_dat0", q_dat[0], pk(6, -1));
        if (q_dat.size() > 1) check("err_dat1", q_dat[1], pk(8, -3));
        q_dat.delete();
        q_last.delete();
        send_frame(0, 1'b0, 1'b0, 16, 15, 1'b0);
        expect_frame("resync", pk(6, -1), pk(8, -3), pk(14, -9), pk(16, -11));
        check("err_sticky", frame_err, 1);

        // Reset mid-frame with a pending output
        out_ready = 1'b0;
        send_frame(0, 1'b1, 1'b1, 6, -1, 1'b0);
        check("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_err", frame_err, 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        q_dat.delete();
        q_last.delete();

        // Average frame with mode toggled after the first beat
        send_frame(0, 1'b1, 1'b0, 16, 15, 1'b0);
        expect_frame("rst_avg", pk(3, -4), pk(5, -6), pk(11, -12), pk(13, -14));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
